fsm_in_queue: RTL and testbench

Byte queue sitting directly upstream of the three-phase output FSM. It accepts bytes from a producer over a valid/ready handshake and buffers them in a small circular FIFO. It drives the FSM's `fsm_in_q` input with the head byte, and pops that byte exactly when the FSM consumes it. The FSM has no handshake of its own, so this block mirrors the FSM's fixed IDLE→WORK→DONE schedule with an internal phase counter reset by the same `rst`.

---
 rtl/fsm_in_queue_if.sv | 27 ++
 rtl/fsm_in_queue.sv | 89 ++++++++
 tb/tb_fsm_in_queue.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/fsm_in_queue_if.sv
// rtl/fsm_in_queue_if.sv - producer/FSM-side bundle for the FSM input byte queue
interface fsm_in_queue_if #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 8
) ();
   localparam int CW = $clog2(DEPTH) + 1;

   logic [WIDTH-1:0] in_data;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] fsm_in_q;
   logic [1:0]       phase;
   logic [CW-1:0]    q_count;
   logic [7:0]       underrun_cnt;

   // Producer / observer side
   modport master (
      output in_data, in_valid,
      input  in_ready, fsm_in_q, phase, q_count, underrun_cnt
   );

   // Queue side
   modport slave (
      input  in_data, in_valid,
      output in_ready, fsm_in_q, phase, q_count, underrun_cnt
   );
endinterface

// File: rtl/fsm_in_queue.sv
// rtl/fsm_in_queue.sv - circular byte FIFO feeding the three-phase output FSM
module fsm_in_queue #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 8
) (
   input  logic           clk,
   input  logic           rst,
   fsm_in_queue_if.slave  q
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   // Mirror of the FSM's fixed schedule
   localparam logic [1:0] PH_IDLE = 2'd0;
   localparam logic [1:0] PH_WORK = 2'd1;
   localparam logic [1:0] PH_DONE = 2'd2;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wp;
   logic [AW-1:0]    rp;
   logic [CW-1:0]    count;
   logic [1:0]       phase;
   logic [7:0]       underrun_cnt;

   logic push;
   logic pop;
   logic underrun;
   logic empty;
   logic full;

   assign empty    = (count == '0);
   assign full     = (count == CW'(DEPTH));
   // Ready depends only on registered occupancy, so a same-cycle pop never frees a slot early
   assign push     = q.in_valid && !full;
   assign pop      = (phase == PH_WORK) && !empty;
   assign underrun = (phase == PH_WORK) && empty;

   assign q.in_ready     = !full;
   assign q.fsm_in_q     = empty ? '0 : mem[rp];
   assign q.phase        = phase;
   assign q.q_count      = count;
   assign q.underrun_cnt = underrun_cnt;

   // Phase counter tracks IDLE->WORK->DONE with no stall, reset together with the FSM
   always_ff @(posedge clk) begin
      if (rst) begin
         phase <= PH_IDLE;
      end else begin
         phase <= (phase == PH_DONE) ? PH_IDLE : phase + 2'd1;
      end
   end

   // Storage write; contents are left unreset since occupancy gates visibility
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wp] <= q.in_data;
      end
   end

   // Pointer and occupancy bookkeeping; simultaneous push/pop leaves count unchanged
   always_ff @(posedge clk) begin
      if (rst) begin
         wp    <= '0;
         rp    <= '0;
         count <= '0;
      end else begin
         if (push) begin
            wp <= wp + AW'(1);
         end
         if (pop) begin
            rp <= rp + AW'(1);
         end
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   // Saturating count of WORK phases that found nothing to present
   always_ff @(posedge clk) begin
      if (rst) begin
         underrun_cnt <= 8'd0;
      end else if (underrun && (underrun_cnt != 8'hFF)) begin
         underrun_cnt <= underrun_cnt + 8'd1;
      end
   end
endmodule

// File: tb/tb_fsm_in_queue.sv
// tb/tb_fsm_in_queue.sv - directed self-checking bench for fsm_in_queue
module tb_fsm_in_queue;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_tests = 0;
   int   n_fail  = 0;

   always #5 clk = ~clk;

   fsm_in_queue_if #(.DEPTH(4), .WIDTH(8)) bus ();

   fsm_in_queue #(.DEPTH(4), .WIDTH(8)) dut (
      .clk (clk),
      .rst (rst),
      .q   (bus)
   );

   task automatic check_eq(input string tag, input int got, input int exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Leaves the bench at the start of cycle 0 after release
   task automatic do_reset();
      rst          = 1'b1;
      bus.in_valid = 1'b0;
      bus.in_data  = 8'h00;
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   initial begin
      int fill_cnt [11];
      int fill_q   [11];
      int wr;
      int rd_exp;
      int c;
      bit acc;

      fill_cnt = '{0, 1, 1, 2, 3, 2, 2, 2, 1, 1, 1};
      fill_q   = '{8'h00, 8'h10, 8'h20, 8'h20, 8'h20, 8'h30, 8'h30, 8'h30, 8'h40, 8'h40, 8'h40};

      // Reset then idle
      do_reset();
      @(negedge clk);
      check_eq("rst_count", int'(bus.q_count), 0);
      check_eq("rst_ready", int'(bus.in_ready), 1);
      check_eq("rst_under", int'(bus.underrun_cnt), 0);
      for (int i = 0; i < 9; i++) begin
         if (i > 0) @(negedge clk);
         check_eq("idle_phase", int'(bus.phase), i % 3);
         check_eq("idle_q", int'(bus.fsm_in_q), 0);
         if (i == 2) check_eq("idle_under1", int'(bus.underrun_cnt), 1);
         if (i == 5) check_eq("idle_under2", int'(bus.underrun_cnt), 2);
         if (i == 8) check_eq("idle_under3", int'(bus.underrun_cnt), 3);
         next_cycle();
      end

      // Single byte
      do_reset();
      bus.in_valid = 1'b1;
      bus.in_data  = 8'hA5;
      @(negedge clk);
      check_eq("one_c0_q", int'(bus.fsm_in_q), 0);
      next_cycle();
      bus.in_valid = 1'b0;
      @(negedge clk);
      check_eq("one_c1_phase", int'(bus.phase), 1);
      check_eq("one_c1_q", int'(bus.fsm_in_q), 8'hA5);
      check_eq("one_c1_abcd", int'(bus.fsm_in_q[7:4]), 4'b1010);
      check_eq("one_c1_count", int'(bus.q_count), 1);
      next_cycle();
      @(negedge clk);
      check_eq("one_c2_count", int'(bus.q_count), 0);
      check_eq("one_c2_q", int'(bus.fsm_in_q), 0);
      check_eq("one_c2_under", int'(bus.underrun_cnt), 0);

      // Fill and order: four bytes back-to-back from cycle 0
      do_reset();
      for (int i = 0; i < 11; i++) begin
         bus.in_valid = (i < 4);
         bus.in_data  = 8'((i + 1) << 4);
         @(negedge clk);
         check_eq("fill_count", int'(bus.q_count), fill_cnt[i]);
         check_eq("fill_q", int'(bus.fsm_in_q), fill_q[i]);
         check_eq("fill_ready", int'(bus.in_ready), 1);
         next_cycle();
      end
      @(negedge clk);
      check_eq("fill_drained", int'(bus.q_count), 0);
      check_eq("fill_under", int'(bus.underrun_cnt), 0);

      // Sustained push with queue at/near full, scoreboarded
      do_reset();
      wr     = 0;
      rd_exp = 0;
      c      = 0;
      bus.in_valid = 1'b1;
      while (rd_exp < 30 && c < 200) begin
         bus.in_data = 8'(wr);
         @(negedge clk);
         acc = bus.in_ready;
         if (c % 3 == 1) begin
            check_eq("sb_byte", int'(bus.fsm_in_q), rd_exp);
            rd_exp++;
         end
         if (c >= 5) begin
            check_eq("sb_count", int'(bus.q_count), (c % 3 == 2) ? 3 : 4);
            check_eq("sb_ready", int'(bus.in_ready), (c % 3 == 2) ? 1 : 0);
         end
         next_cycle();
         if (acc) wr++;
         c++;
      end
      bus.in_valid = 1'b0;
      check_eq("sb_consumed", rd_exp, 30);
      check_eq("sb_last_cycle", c, 89);
      @(negedge clk);
      check_eq("sb_under", int'(bus.underrun_cnt), 0);

      // Reset mid-operation during DONE
      do_reset();
      for (int i = 0; i < 5; i++) begin
         bus.in_valid = (i < 4);
         bus.in_data  = 8'(8'hB0 + i);
         next_cycle();
      end
      bus.in_valid = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      check_eq("mid_pre_phase", int'(bus.phase), 2);
      check_eq("mid_pre_count", int'(bus.q_count), 2);
      next_cycle();
      rst = 1'b0;
      @(negedge clk);
      check_eq("mid_count", int'(bus.q_count), 0);
      check_eq("mid_phase", int'(bus.phase), 0);
      check_eq("mid_q", int'(bus.fsm_in_q), 0);
      check_eq("mid_ready", int'(bus.in_ready), 1);
      next_cycle();
      @(negedge clk);
      check_eq("mid_work_q", int'(bus.fsm_in_q), 0);
      next_cycle();
      @(negedge clk);
      check_eq("mid_under", int'(bus.underrun_cnt), 1);

      // Underrun saturation over 800 empty cycles
      do_reset();
      for (int i = 0; i < 800; i++) begin
         @(negedge clk);
         if (i == 763) check_eq("sat_254", int'(bus.underrun_cnt), 254);
         if (i == 766) check_eq("sat_255", int'(bus.underrun_cnt), 255);
         if (i == 799) check_eq("sat_hold", int'(bus.underrun_cnt), 255);
         next_cycle();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
